seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_pattern_decode.sv | 27 ++
 rtl/seg7_scan_decoder.sv | 98 +++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment decoder: segment patterns,
// output codes and the frame FSM state type.
package seg7_pkg;
  localparam int NUM_DIG = 4;

  // Segment order {a,b,c,d,e,f,g}, a in bit 6, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ERR   = 4'hE;

  typedef enum logic {COLLECT = 1'b0, PUBLISH = 1'b1} state_t;
endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decode; unknown patterns flag invalid.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] code,
  output logic       invalid
);
  always_comb begin
    code    = CODE_ERR;
    invalid = 1'b0;
    case (pat)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   invalid = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// Debounces a multiplexed 4-digit 7-segment scan and publishes whole frames
// once every digit has been seen STABLE_CNT times in a row.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_sel,
  input  logic        sample_en,
  output logic [15:0] value_out,
  output logic        frame_valid,
  output logic [3:0]  err_digit
);
  localparam logic [3:0] STABLE = 4'(STABLE_CNT);

  logic [3:0]                  dec_code;
  logic                        dec_inv;
  logic                        sample_ok;
  logic [NUM_DIG-1:0][6:0]     last_pat_q, last_pat_d;
  logic [NUM_DIG-1:0][3:0]     cnt_q, cnt_d;
  logic [NUM_DIG-1:0][3:0]     shd_q, shd_d;
  logic [NUM_DIG-1:0]          shd_err_q, shd_err_d;
  logic [NUM_DIG-1:0]          cap_q, cap_d;
  state_t                      state_q, state_d;

  // One decoder serves whichever digit is currently selected
  seg7_pattern_decode u_dec (
    .pat     (seg_in),
    .code    (dec_code),
    .invalid (dec_inv)
  );

  assign sample_ok = sample_en && (dig_sel != 4'd0) &&
                     ((dig_sel & (dig_sel - 4'd1)) == 4'd0);

  always_comb begin
    last_pat_d = last_pat_q;
    cnt_d      = cnt_q;
    shd_d      = shd_q;
    shd_err_d  = shd_err_q;
    // Clear on publish first so a same-cycle capture still sticks
    cap_d      = (state_q == PUBLISH) ? '0 : cap_q;
    for (int k = 0; k < NUM_DIG; k++) begin
      if (sample_ok && dig_sel[k]) begin
        if (seg_in == last_pat_q[k]) begin
          cnt_d[k] = (cnt_q[k] >= STABLE) ? STABLE : cnt_q[k] + 4'd1;
        end else begin
          last_pat_d[k] = seg_in;
          cnt_d[k]      = 4'd1;
        end
        if (cnt_d[k] >= STABLE) begin
          shd_d[k]     = dec_code;
          shd_err_d[k] = dec_inv;
          cap_d[k]     = 1'b1;
        end
      end
    end
  end

  // Entering PUBLISH on the capturing edge puts frame_valid in the next cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (cap_d == 4'hF) state_d = PUBLISH;
      PUBLISH: state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  assign frame_valid = (state_q == PUBLISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      last_pat_q <= '0;
      cnt_q      <= '0;
      shd_q      <= {NUM_DIG{CODE_BLANK}};
      shd_err_q  <= '0;
      cap_q      <= '0;
      value_out  <= 16'hFFFF;
      err_digit  <= 4'b0000;
    end else begin
      state_q    <= state_d;
      last_pat_q <= last_pat_d;
      cnt_q      <= cnt_d;
      shd_q      <= shd_d;
      shd_err_q  <= shd_err_d;
      cap_q      <= cap_d;
      if (state_q == COLLECT && state_d == PUBLISH) begin
        value_out <= shd_d;
        err_digit <= shd_err_d;
      end
    end
  end
endmodule
